prime_uart_streamer: RTL and testbench
======================================

// Module: prime_uart_streamer
// PURPOSE
//  Downstream consumer of primogen on the icestick board. Requests successive primes
//  via the go/ready handshake and converts each result to ASCII decimal. Streams each
//  one over a UART TX line (8N1) so a host can log the sequence. Halts on generator error.
// PARAMETERS
//  W       16        primogen result width; decimal digit count ND = ceil(W*log10(2))
//  CLK_HZ  12000000  clk frequency in Hz
//  BAUD    115200    UART bit rate; DIV = CLK_HZ/BAUD (integer, truncated; 104 at defaults)
// PORTS
//  clk       in   1  single clock, all logic rising-edge
//  rst       in   1  asynchronous, active-high reset
//  pg_go     out  1  one-cycle request pulse to primogen
//  pg_ready  in   1  primogen ready
//  pg_error  in   1  primogen overflow/error, valid with pg_ready
//  pg_res    in   W  primogen result, valid with pg_ready
//  uart_tx   out  1  serial output, idle high
//  busy      out  1  high from capture until last frame stop bit completes
//  halted    out  1  sticky; set after error message fully sent
//  count     out  16 primes transmitted; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): uart_tx=1, pg_go=0, busy=0, halted=0, count=0, FSM=REQ, divider/bit counters=0.
//  FSM: REQ -> ARM -> WAIT -> CONV -> SEND -> TERM -> REQ; error path: WAIT -> ERR -> TERM -> HALT.
//  REQ : when pg_ready=1 assert pg_go for exactly one cycle, go to ARM; pg_ready=0 -> stay, pg_go=0.
//  ARM : one dead cycle so primogen registers go (pg_ready ignored this cycle).
//  WAIT: on pg_ready=1 latch pg_res/pg_error same edge; error=1 -> ERR, else CONV; busy rises next cycle.
//  CONV: iterative double-dabble, one input bit per cycle, exactly W cycles -> ND BCD digits.
//  SEND: emit digits MS first as 8'h30+digit; leading zeros suppressed, value 0 sends "0".
//  ERR : emit 8'h45 ('E').
//  TERM: emit terminator (see CONFIGURATION); after final stop bit: normal path count+=1
//        (saturating) and -> REQ; error path -> HALT.
//  HALT: halted=1, busy=0, pg_go never asserted again until rst.
//  UART frame: start(0), 8 data LSB first, stop(1); each bit held exactly DIV cycles; consecutive
//        bytes back-to-back (next start bit immediately after previous stop bit's DIV cycles).
//  Byte-to-byte latency from CONV end: first start bit begins on cycle after CONV's last cycle.
//  pg_go never asserted while busy=1 or in ARM/WAIT; never two pulses without an intervening capture.
//  pg_res/pg_error changes outside WAIT capture edge are ignored (latched copy used).
//  Reset mid-frame: uart_tx returns high asynchronously; partial byte abandoned, no resend.
//  Digits held in ND x 4-bit registers; shift register width W+4*ND; no combinational divide.
// CONFIGURATION
//  PRIME_STREAM_CRLF_EN defined : terminator is 2 bytes 8'h0D,8'h0A ("\r\n").
//  PRIME_STREAM_CRLF_EN undefined: terminator is 1 byte 8'h20 (space); all else identical.
// TESTING (DIV forced to 4 in bench for speed unless noted; CRLF_EN defined unless noted)
//  1. pg_ready=1, pg_res=2 -> one pg_go pulse; bytes 32 0D 0A decoded; count=1, busy falls after
//     last stop bit.
//  2. pg_res=16'hFFF1 (65521) -> bytes 36 35 35 32 31 0D 0A; pg_res=0 -> 30 0D 0A; pg_res=10
//     -> 31 30 0D 0A.
//  3. pg_ready=1, pg_error=1 -> bytes 45 0D 0A, then halted=1, pg_go stays 0 for 1000 cycles,
//     count unchanged.
//  4. pg_ready held 0 after reset -> pg_go=0, uart_tx=1, busy=0 indefinitely; raise
//     pg_ready -> single pg_go pulse next cycle.
//  5. Assert rst mid start/data bit -> uart_tx=1, pg_go=0, count=0 immediately; after release
//     stream restarts with fresh pg_go.
//  6. Defaults (DIV=104), CRLF_EN undefined, pg_res=7 -> each bit exactly 104 cycles;
//     bytes 37 20; frame spacing 1040 cycles.

Source files
------------

// File: rtl/prime_uart_streamer.sv
// prime_uart_streamer
//   Consumer of primogen: requests successive primes over the go/ready
//   handshake, converts each result to ASCII decimal with an iterative
//   double-dabble, and streams the text over an 8N1 UART transmitter.
//   A generator error sends "E" plus the terminator and then halts.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   pg_go     out  1   one-cycle request pulse to primogen
//   pg_ready  in   1   primogen ready
//   pg_error  in   1   primogen error, valid with pg_ready
//   pg_res    in   W   primogen result, valid with pg_ready
//   uart_tx   out  1   serial output, idle high
//   busy      out  1   high from capture until the last stop bit completes
//   halted    out  1   sticky, set once the error message has been sent
//   count     out  16  primes transmitted, saturating
//
// Configuration macro
//   PRIME_STREAM_CRLF_EN : defined -> terminator "\r\n", undefined -> " ".

module prime_uart_streamer #(
    parameter int unsigned W      = 16,
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic         clk,
    input  logic         rst,
    output logic         pg_go,
    input  logic         pg_ready,
    input  logic         pg_error,
    input  logic [W-1:0] pg_res,
    output logic         uart_tx,
    output logic         busy,
    output logic         halted,
    output logic [15:0]  count
);

    // Decimal digits needed for the largest W-bit value (elaboration only).
    function automatic int unsigned calc_nd(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int unsigned ND  = calc_nd(W);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned IW  = (ND > 1) ? $clog2(ND) : 1;
    localparam int unsigned SW  = W + 4 * ND;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(W - 1);

`ifdef PRIME_STREAM_CRLF_EN
    localparam logic [7:0] TERM0 = 8'h0D;
`else
    localparam logic [7:0] TERM0 = 8'h20;
`endif

    typedef enum logic [2:0] {
        S_REQ, S_ARM, S_WAIT, S_CONV, S_SEND, S_ERR, S_TERM, S_HALT
    } state_t;

    // Index of the most significant non-zero digit; 0 when the value is 0,
    // so a zero result still emits a single "0".
    function automatic logic [IW-1:0] msd_of(input logic [4*ND-1:0] b);
        logic [IW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (b[4*i +: 4] != 4'd0) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] digit_at(input logic [4*ND-1:0] b,
                                            input logic [IW-1:0]   idx);
        return b[int'(idx) * 4 +: 4];
    endfunction

    state_t        state_q, state_d;
    logic          pg_go_q, pg_go_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic [15:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [SW-1:0] sh_q, sh_d;          // {BCD digits, binary} double-dabble register
    logic [CW-1:0] conv_cnt_q, conv_cnt_d;
    logic [IW-1:0] dig_idx_q, dig_idx_d;
`ifdef PRIME_STREAM_CRLF_EN
    logic          term_idx_q, term_idx_d;
`endif
    logic          tx_active_q, tx_active_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          uart_tx_q, uart_tx_d;

    logic          tx_done;
    logic          load;
    logic [7:0]    load_byte;
    logic          finish;
    logic [SW-1:0] dd_adj;
    logic [SW-1:0] dd_next;
    logic [IW-1:0] first_idx;

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        dd_adj = sh_q;
        for (int unsigned i = 0; i < ND; i++) begin
            if (dd_adj[W + 4*i +: 4] >= 4'd5) begin
                dd_adj[W + 4*i +: 4] = dd_adj[W + 4*i +: 4] + 4'd3;
            end
        end
        dd_next = dd_adj << 1;
    end

    always_comb begin
        state_d     = state_q;
        pg_go_d     = 1'b0;
        busy_d      = busy_q;
        halted_d    = halted_q;
        count_d     = count_q;
        err_d       = err_q;
        sh_d        = sh_q;
        conv_cnt_d  = conv_cnt_q;
        dig_idx_d   = dig_idx_q;
`ifdef PRIME_STREAM_CRLF_EN
        term_idx_d  = term_idx_q;
`endif
        tx_active_d = tx_active_q;
        tx_data_d   = tx_data_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        uart_tx_d   = uart_tx_q;
        load        = 1'b0;
        load_byte   = 8'h00;
        finish      = 1'b0;
        first_idx   = msd_of(dd_next[SW-1:W]);
        tx_done     = tx_active_q && (div_cnt_q == DIV_LAST) && (bit_cnt_q == 4'd9);

        case (state_q)
            S_REQ: begin
                if (pg_ready) begin
                    pg_go_d = 1'b1;
                    state_d = S_ARM;
                end
            end
            S_ARM: state_d = S_WAIT;
            S_WAIT: begin
                if (pg_ready) begin
                    err_d      = pg_error;
                    sh_d       = SW'(pg_res);
                    conv_cnt_d = '0;
                    busy_d     = 1'b1;
                    if (pg_error) begin
                        load      = 1'b1;
                        load_byte = 8'h45;
                        state_d   = S_ERR;
                    end else begin
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                sh_d       = dd_next;
                conv_cnt_d = conv_cnt_q + CW'(1);
                // First digit is loaded from the step's result so the start
                // bit begins on the cycle right after the last conversion cycle.
                if (conv_cnt_q == CONV_LAST) begin
                    load      = 1'b1;
                    load_byte = {4'h3, digit_at(dd_next[SW-1:W], first_idx)};
                    dig_idx_d = first_idx;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_done) begin
                    load = 1'b1;
                    if (dig_idx_q == '0) begin
                        load_byte = TERM0;
`ifdef PRIME_STREAM_CRLF_EN
                        term_idx_d = 1'b0;
`endif
                        state_d = S_TERM;
                    end else begin
                        dig_idx_d = dig_idx_q - IW'(1);
                        load_byte = {4'h3, digit_at(sh_q[SW-1:W], dig_idx_q - IW'(1))};
                    end
                end
            end
            S_ERR: begin
                if (tx_done) begin
                    load      = 1'b1;
                    load_byte = TERM0;
`ifdef PRIME_STREAM_CRLF_EN
                    term_idx_d = 1'b0;
`endif
                    state_d = S_TERM;
                end
            end
            S_TERM: begin
                if (tx_done) begin
`ifdef PRIME_STREAM_CRLF_EN
                    if (!term_idx_q) begin
                        load       = 1'b1;
                        load_byte  = 8'h0A;
                        term_idx_d = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end
            end
            S_HALT: ;
            default: state_d = S_REQ;
        endcase

        if (finish) begin
            busy_d = 1'b0;
            if (err_q) begin
                halted_d = 1'b1;
                state_d  = S_HALT;
            end else begin
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                state_d = S_REQ;
            end
        end

        // Transmitter: a load on the stop bit's final cycle starts the next
        // frame immediately, giving back-to-back bytes.
        if (load) begin
            tx_active_d = 1'b1;
            tx_data_d   = load_byte;
            div_cnt_d   = '0;
            bit_cnt_d   = 4'd0;
            uart_tx_d   = 1'b0;
        end else if (tx_active_q) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                if (bit_cnt_q == 4'd9) begin
                    tx_active_d = 1'b0;
                    uart_tx_d   = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    uart_tx_d = (bit_cnt_q < 4'd8) ? tx_data_q[bit_cnt_q[2:0]] : 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pg_go_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            sh_q        <= '0;
            conv_cnt_q  <= '0;
            dig_idx_q   <= '0;
`ifdef PRIME_STREAM_CRLF_EN
            term_idx_q  <= 1'b0;
`endif
            tx_active_q <= 1'b0;
            tx_data_q   <= '0;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            uart_tx_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            pg_go_q     <= pg_go_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
            err_q       <= err_d;
            sh_q        <= sh_d;
            conv_cnt_q  <= conv_cnt_d;
            dig_idx_q   <= dig_idx_d;
`ifdef PRIME_STREAM_CRLF_EN
            term_idx_q  <= term_idx_d;
`endif
            tx_active_q <= tx_active_d;
            tx_data_q   <= tx_data_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            uart_tx_q   <= uart_tx_d;
        end
    end

    assign pg_go   = pg_go_q;
    assign busy    = busy_q;
    assign halted  = halted_q;
    assign count   = count_q;
    assign uart_tx = uart_tx_q;

endmodule

// File: tb/tb_prime_uart_streamer.sv
module tb_prime_uart_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // DUT with DIV = 4
    logic        pg_ready, pg_error, pg_go, uart_tx, busy, halted;
    logic [15:0] pg_res, count;
    // DUT with default DIV = 104
    logic        pg_ready6, pg_error6, pg_go6, uart_tx6, busy6, halted6;
    logic [15:0] pg_res6, count6;

    prime_uart_streamer #(.W(16), .CLK_HZ(4), .BAUD(1)) u_dut (
        .clk(clk), .rst(rst), .pg_go(pg_go), .pg_ready(pg_ready),
        .pg_error(pg_error), .pg_res(pg_res), .uart_tx(uart_tx),
        .busy(busy), .halted(halted), .count(count)
    );

    prime_uart_streamer u_dut6 (
        .clk(clk), .rst(rst), .pg_go(pg_go6), .pg_ready(pg_ready6),
        .pg_error(pg_error6), .pg_res(pg_res6), .uart_tx(uart_tx6),
        .busy(busy6), .halted(halted6), .count(count6)
    );

`ifdef PRIME_STREAM_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;
    int go_cnt = 0, go_cnt6 = 0, viol = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp6_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pg_go === 1'b1) go_cnt++;
        if (pg_go6 === 1'b1) go_cnt6++;
        if (pg_go === 1'b1 && busy === 1'b1) viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_term(input bit six);
        if (CRLF) begin
            if (six) begin exp6_q.push_back(8'h0D); exp6_q.push_back(8'h0A); end
            else     begin exp_q.push_back(8'h0D);  exp_q.push_back(8'h0A);  end
        end else begin
            if (six) exp6_q.push_back(8'h20);
            else     exp_q.push_back(8'h20);
        end
    endtask

    // Samples one frame whose start bit was just seen; every bit must hold
    // its value for exactly div samples.
    task automatic uart_rx(input bit six, input int unsigned div, output logic [7:0] data,
                           output bit framing_ok, output bit steady, output bit aborted);
        logic [9:0] bits;
        logic s;
        bits = '0; data = '0; framing_ok = 1'b0; steady = 1'b1; aborted = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            for (int unsigned j = 0; j < div; j++) begin
                if (!(k == 0 && j == 0)) @(negedge clk);
                if (rst === 1'b1) begin aborted = 1'b1; return; end
                s = six ? uart_tx6 : uart_tx;
                if (j == 0) bits[k] = s;
                else if (s !== bits[k]) steady = 1'b0;
            end
        end
        data = bits[8:1];
        framing_ok = (bits[0] == 1'b0) && (bits[9] == 1'b1);
    endtask

    initial begin : mon0
        logic [7:0] d, e;
        bit fo, st, ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx === 1'b0) begin
                uart_rx(1'b0, 4, d, fo, st, ab);
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_byte: got %02h, expected none", d);
                    end else begin
                        e = exp_q.pop_front();
                        check("uart_byte", d, e);
                        check("uart_frame", {fo, st}, 2'b11);
                    end
                end
            end
        end
    end

    initial begin : mon6
        logic [7:0] d, e;
        bit fo, st, ab, have_last;
        int unsigned t0, last;
        have_last = 1'b0; last = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && uart_tx6 === 1'b0) begin
                t0 = cyc;
                if (have_last && (t0 - last) < 2000) check("frame_spacing6", t0 - last, 1040);
                last = t0; have_last = 1'b1;
                uart_rx(1'b1, 104, d, fo, st, ab);
                if (!ab) begin
                    if (exp6_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_byte6: got %02h, expected none", d);
                    end else begin
                        e = exp6_q.pop_front();
                        check("uart_byte6", d, e);
                        check("uart_frame6", {fo, st}, 2'b11);
                    end
                end
            end
        end
    end

    task automatic wait_busy(input bit six, input logic val, input int unsigned max, input string name);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while ((six ? busy6 : busy) !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, six ? busy6 : busy, val);
    endtask

    task automatic txn0(input logic [15:0] res, input logic err, input int exp_count, input string tag);
        int g;
        g = go_cnt;
        pg_res = res; pg_error = err; pg_ready = 1'b1;
        @(negedge clk);
        check({tag, "_go_pulse"}, pg_go, 1'b1);
        wait_busy(1'b0, 1'b1, 50, {tag, "_busy_rise"});
        // Inputs change after capture; the latched copy must be used.
        pg_ready = 1'b0; pg_res = 16'hA5A5; pg_error = ~err;
        wait_busy(1'b0, 1'b0, 3000, {tag, "_busy_fall"});
        pg_error = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_count"}, count, exp_count);
        check({tag, "_go_count"}, go_cnt - g, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : stim
        int unsigned n;
        int g;
        rst = 1'b1;
        pg_ready = 1'b0; pg_error = 1'b0; pg_res = '0;
        pg_ready6 = 1'b0; pg_error6 = 1'b0; pg_res6 = '0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_pg_go", pg_go, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_count", count, 16'd0);
        rst = 1'b0;

        // Idle with pg_ready low
        repeat (60) @(negedge clk);
        check("idle_go_count", go_cnt, 0);
        check("idle_uart_tx", uart_tx, 1'b1);
        check("idle_busy", busy, 1'b0);

        exp_q.push_back(8'h32); push_term(1'b0);
        txn0(16'd2, 1'b0, 1, "two");

        exp_q.push_back(8'h36); exp_q.push_back(8'h35); exp_q.push_back(8'h35);
        exp_q.push_back(8'h32); exp_q.push_back(8'h31); push_term(1'b0);
        txn0(16'hFFF1, 1'b0, 2, "p65521");

        exp_q.push_back(8'h30); push_term(1'b0);
        txn0(16'd0, 1'b0, 3, "zero");

        exp_q.push_back(8'h31); exp_q.push_back(8'h30); push_term(1'b0);
        txn0(16'd10, 1'b0, 4, "ten");

        // Reset in the middle of a frame
        exp_q.push_back(8'h32); push_term(1'b0);
        pg_res = 16'd2; pg_ready = 1'b1;
        n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check("midrst_start_seen", uart_tx, 1'b0);
        pg_ready = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_uart_tx", uart_tx, 1'b1);
        check("midrst_pg_go", pg_go, 1'b0);
        check("midrst_count", count, 16'd0);
        check("midrst_busy", busy, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8'h32); push_term(1'b0);
        txn0(16'd2, 1'b0, 1, "restart");

        // Error path
        exp_q.push_back(8'h45); push_term(1'b0);
        pg_res = 16'd13; pg_error = 1'b1; pg_ready = 1'b1;
        wait_busy(1'b0, 1'b1, 50, "err_busy_rise");
        pg_ready = 1'b0; pg_error = 1'b0;
        wait_busy(1'b0, 1'b0, 3000, "err_busy_fall");
        repeat (2) @(negedge clk);
        check("err_drained", exp_q.size(), 0);
        check("err_halted", halted, 1'b1);
        check("err_count", count, 16'd1);
        g = go_cnt;
        pg_ready = 1'b1;
        repeat (1000) @(negedge clk);
        check("halt_no_go", go_cnt - g, 0);
        check("halt_busy", busy, 1'b0);
        check("halt_uart_tx", uart_tx, 1'b1);
        check("halt_sticky", halted, 1'b1);
        pg_ready = 1'b0;

        // Default-rate instance, value 7
        exp6_q.push_back(8'h37); push_term(1'b1);
        pg_res6 = 16'd7; pg_ready6 = 1'b1;
        wait_busy(1'b1, 1'b1, 50, "d6_busy_rise");
        pg_ready6 = 1'b0; pg_res6 = 16'h1234;
        wait_busy(1'b1, 1'b0, 6000, "d6_busy_fall");
        repeat (2) @(negedge clk);
        check("d6_drained", exp6_q.size(), 0);
        check("d6_count", count6, 16'd1);
        check("d6_go_count", go_cnt6, 1);

        check("go_while_busy", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
